// File: rtl/rand_range_gen_if.sv
// rand_range_gen_if: seed/draw port bundle of the bounded random source.
// The master side (carve FSM) seeds the LFSRs and requests draws; the slave
// side (rand_range_gen) returns the result with a one-cycle valid pulse.
interface rand_range_gen_if #(
    parameter int unsigned OUT_W = 2,
    parameter int unsigned A_W   = 23,
    parameter int unsigned B_W   = 21
);
    logic             seed_load;
    logic [A_W-1:0]   seed_a;
    logic [B_W-1:0]   seed_b;
    logic             req;
    logic [OUT_W:0]   limit;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] rnd;
    logic             fallback;
    logic [15:0]      reject_cnt;

    modport master (
        output seed_load, seed_a, seed_b, req, limit,
        input  busy, valid, rnd, fallback, reject_cnt
    );

    modport slave (
        input  seed_load, seed_a, seed_b, req, limit,
        output busy, valid, rnd, fallback, reject_cnt
    );
endinterface

// File: rtl/rand_range_gen.sv
// rand_range_gen: uniform draw in [0, limit-1] from two free-running
// Fibonacci LFSRs using bounded rejection sampling. A draw that keeps
// rejecting for MAX_TRIES samples returns 0 with the fallback flag set.
// Optional build macro: RAND_STATS_EN adds a saturating rejection counter
// on reject_cnt; without it reject_cnt is tied to zero.
module rand_range_gen #(
    parameter int unsigned    OUT_W     = 2,
    parameter int unsigned    A_W       = 23,
    parameter int unsigned    A_TAP     = 17,
    parameter logic [A_W-1:0] A_SEED    = 23'h5A_DB6A,
    parameter int unsigned    B_W       = 21,
    parameter int unsigned    B_TAP     = 18,
    parameter logic [B_W-1:0] B_SEED    = 21'h16_D2AE,
    parameter int unsigned    MAX_TRIES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rand_range_gen_if.slave      bus_if
);

    // Retry counter must be able to hold MAX_TRIES itself for the compare.
    localparam int unsigned        TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   TRY_ONE  = TRY_W'(1);
    localparam logic [TRY_W-1:0]   TRY_ZERO = TRY_W'(0);
    localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES);
    // Largest legal limit: every sample value is a valid choice.
    localparam logic [OUT_W:0]     LIM_MAX  = {1'b1, {OUT_W{1'b0}}};
    localparam logic [OUT_W:0]     LIM_ONE  = {{OUT_W{1'b0}}, 1'b1};
    localparam logic [OUT_W:0]     LIM_ZERO = {(OUT_W+1){1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_t;

    // One Fibonacci shift of LFSR A: feedback enters at bit 0.
    function automatic logic [A_W-1:0] lfsr_a_step(input logic [A_W-1:0] v);
        return {v[A_W-2:0], v[A_W-1] ^ v[A_TAP]};
    endfunction

    // One Fibonacci shift of LFSR B.
    function automatic logic [B_W-1:0] lfsr_b_step(input logic [B_W-1:0] v);
        return {v[B_W-2:0], v[B_W-1] ^ v[B_TAP]};
    endfunction

    // Map a requested limit onto 1..2^OUT_W so a draw always has a choice.
    function automatic logic [OUT_W:0] clamp_limit(input logic [OUT_W:0] lim);
        logic [OUT_W:0] r;
        if (lim == LIM_ZERO) begin
            r = LIM_ONE;
        end else if (lim > LIM_MAX) begin
            r = LIM_MAX;
        end else begin
            r = lim;
        end
        return r;
    endfunction

    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W:0]   limit_q, limit_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] rnd_q, rnd_d;
    logic             fallback_q, fallback_d;

    logic [OUT_W-1:0] sample_s;
    logic             accept_s;
    logic [TRY_W-1:0] tries_inc_s;

    // Sample is taken from the LFSR state that is current this cycle.
    assign sample_s    = a_q[OUT_W-1:0] ^ b_q[OUT_W-1:0];
    assign accept_s    = ({1'b0, sample_s} < limit_q);
    assign tries_inc_s = tries_q + TRY_ONE;

    // LFSR next state: a seed load wins over the free-running advance, and a
    // zero seed is replaced by the default so the lock-up state never occurs.
    always_comb begin
        a_d = lfsr_a_step(a_q);
        b_d = lfsr_b_step(b_q);
        if (bus_if.seed_load) begin
            if (bus_if.seed_a == {A_W{1'b0}}) begin
                a_d = A_SEED;
            end else begin
                a_d = bus_if.seed_a;
            end
            if (bus_if.seed_b == {B_W{1'b0}}) begin
                b_d = B_SEED;
            end else begin
                b_d = bus_if.seed_b;
            end
        end else begin
            a_d = lfsr_a_step(a_q);
            b_d = lfsr_b_step(b_q);
        end
    end

    // Draw FSM: accept a request in IDLE, then test one sample per cycle
    // until it falls below the limit or the retry budget runs out.
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        limit_d    = limit_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        rnd_d      = rnd_q;
        fallback_d = fallback_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.req) begin
                    limit_d = clamp_limit(bus_if.limit);
                    tries_d = TRY_ZERO;
                    state_d = ST_DRAW;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_DRAW: begin
                if (accept_s) begin
                    rnd_d      = sample_s;
                    fallback_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                end else begin
                    tries_d = tries_inc_s;
                    if (tries_inc_s == TRY_LAST) begin
                        rnd_d      = {OUT_W{1'b0}};
                        fallback_d = 1'b1;
                        valid_d    = 1'b1;
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                    end else begin
                        state_d = ST_DRAW;
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q        <= A_SEED;
            b_q        <= B_SEED;
            state_q    <= ST_IDLE;
            tries_q    <= TRY_ZERO;
            limit_q    <= LIM_ONE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            rnd_q      <= {OUT_W{1'b0}};
            fallback_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            state_q    <= state_d;
            tries_q    <= tries_d;
            limit_q    <= limit_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            rnd_q      <= rnd_d;
            fallback_q <= fallback_d;
        end
    end

    assign bus_if.busy     = busy_q;
    assign bus_if.valid    = valid_q;
    assign bus_if.rnd      = rnd_q;
    assign bus_if.fallback = fallback_q;

`ifdef RAND_STATS_EN
    logic        reject_s;
    logic [15:0] rej_q, rej_d;

    // A rejection is any DRAW cycle whose sample misses the limit,
    // including the last one that triggers the fallback.
    assign reject_s = (state_q == ST_DRAW) && !accept_s;

    // Saturating rejection counter; a reseed starts a fresh statistic.
    always_comb begin
        rej_d = rej_q;
        if (bus_if.seed_load) begin
            rej_d = 16'h0000;
        end else if (reject_s && (rej_q != 16'hFFFF)) begin
            rej_d = rej_q + 16'h0001;
        end else begin
            rej_d = rej_q;
        end
    end

    // Rejection counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rej_q <= 16'h0000;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign bus_if.reject_cnt = rej_q;
`else
    assign bus_if.reject_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rand_range_gen.sv
// tb_rand_range_gen: table-driven draws against an LFSR reference model with
// a scoreboard of predicted results, plus hand sequences for seeding,
// interference, mid-draw reset and forced fallback (second instance with
// MAX_TRIES=1). Honours RAND_STATS_EN for the reject_cnt expectation.
`timescale 1ns/1ps
module tb_rand_range_gen;
    localparam int unsigned MAX_TRIES = 8;
    localparam logic [22:0] A_SEED    = 23'h5A_DB6A;
    localparam logic [20:0] B_SEED    = 21'h16_D2AE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rand_range_gen_if #(.OUT_W(2), .A_W(23), .B_W(21)) if1 ();
    rand_range_gen_if #(.OUT_W(2), .A_W(23), .B_W(21)) if2 ();

    rand_range_gen #(.OUT_W(2), .A_W(23), .A_TAP(17), .A_SEED(A_SEED),
                     .B_W(21), .B_TAP(18), .B_SEED(B_SEED), .MAX_TRIES(MAX_TRIES))
        dut1 (.clk_i(clk), .rst_i(rst), .bus_if(if1));

    rand_range_gen #(.OUT_W(2), .A_W(23), .A_TAP(17), .A_SEED(A_SEED),
                     .B_W(21), .B_TAP(18), .B_SEED(B_SEED), .MAX_TRIES(1))
        dut2 (.clk_i(clk), .rst_i(rst), .bus_if(if2));

    typedef struct {
        logic [2:0]  limit;
        logic [2:0]  exp_lim;
        logic        sl;
        logic [22:0] sa;
        logic [20:0] sbs;
    } vec_t;

    typedef struct {
        logic [1:0] rnd;
        logic       fb;
        int         lat;
        logic [2:0] lim;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [22:0] ma;
    logic [20:0] mb;
    int          mrej = 0;
    int          cnt[4];

    function automatic logic [22:0] nxt_a(input logic [22:0] v);
        return {v[21:0], v[22] ^ v[17]};
    endfunction

    function automatic logic [20:0] nxt_b(input logic [20:0] v);
        return {v[19:0], v[20] ^ v[18]};
    endfunction

    function automatic int exp_rej();
`ifdef RAND_STATS_EN
        return mrej;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: model follows the inputs the DUT samples at this edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma   = A_SEED;
            mb   = B_SEED;
            mrej = 0;
        end else if (if1.seed_load) begin
            ma = (if1.seed_a == 23'h0) ? A_SEED : if1.seed_a;
            mb = (if1.seed_b == 21'h0) ? B_SEED : if1.seed_b;
        end else begin
            ma = nxt_a(ma);
            mb = nxt_b(mb);
        end
        #1;
    endtask

    task automatic start_draw(input logic [2:0] lim_in, input logic [2:0] lim_exp,
                              input logic sl, input logic [22:0] sa, input logic [20:0] sbs);
        exp_t        e;
        logic [22:0] ta;
        logic [20:0] tbv;
        logic [1:0]  s;
        logic        done;
        if1.req = 1'b1; if1.limit = lim_in; if1.seed_load = sl;
        if1.seed_a = sa; if1.seed_b = sbs;
        tick();
        if1.req = 1'b0; if1.seed_load = 1'b0;
        if (sl) mrej = 0;
        e.lim = lim_exp; e.rnd = 2'd0; e.fb = 1'b1; e.lat = MAX_TRIES;
        done = 1'b0; ta = ma; tbv = mb;
        for (int i = 0; i < MAX_TRIES; i++) begin
            if (!done) begin
                s = ta[1:0] ^ tbv[1:0];
                if ({1'b0, s} < lim_exp) begin
                    e.rnd = s; e.fb = 1'b0; e.lat = i + 1; done = 1'b1;
                end else begin
                    mrej++;
                    ta  = nxt_a(ta);
                    tbv = nxt_b(tbv);
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic finish_draw();
        int   lat;
        logic done;
        exp_t e;
        lat = 0; done = 1'b0;
        for (int i = 1; i <= MAX_TRIES + 3; i++) begin
            if (!done) begin
                tick();
                if (if1.valid === 1'b1) begin
                    lat = i; done = 1'b1;
                end
            end
        end
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk("latency", lat, e.lat);
            chk("rand", {30'd0, if1.rnd}, {30'd0, e.rnd});
            chk("fallback", {31'd0, if1.fallback}, {31'd0, e.fb});
            chk("reject_cnt", {16'd0, if1.reject_cnt}, exp_rej());
            if (e.lim == 3'd1) chk("lim1_zero", {30'd0, if1.rnd}, 32'd0);
            if (e.lim == 3'd4) chk("full_first_try", lat, 32'd1);
        end
    endtask

    initial begin
        int   k;
        int   nval;
        exp_t e;

        vecs[0] = '{3'd4, 3'd4, 1'b0, 23'h0, 21'h0};
        vecs[1] = '{3'd3, 3'd3, 1'b0, 23'h0, 21'h0};
        vecs[2] = '{3'd0, 3'd1, 1'b0, 23'h0, 21'h0};
        vecs[3] = '{3'd1, 3'd1, 1'b0, 23'h0, 21'h0};
        vecs[4] = '{3'd7, 3'd4, 1'b0, 23'h0, 21'h0};
        vecs[5] = '{3'd5, 3'd4, 1'b0, 23'h0, 21'h0};
        vecs[6] = '{3'd2, 3'd2, 1'b0, 23'h0, 21'h0};
        vecs[7] = '{3'd4, 3'd4, 1'b1, 23'h0, 21'h0};
        vecs[8] = '{3'd2, 3'd2, 1'b1, 23'h000003, 21'h100000};
        vecs[9] = '{3'd6, 3'd4, 1'b0, 23'h0, 21'h0};

        if1.req = 1'b0; if1.limit = 3'd0; if1.seed_load = 1'b0;
        if1.seed_a = 23'h0; if1.seed_b = 21'h0;
        if2.req = 1'b0; if2.limit = 3'd0; if2.seed_load = 1'b0;
        if2.seed_a = 23'h0; if2.seed_b = 21'h0;

        // Reset for two cycles, then release.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", {31'd0, if1.busy}, 32'd0);
        chk("rst_valid", {31'd0, if1.valid}, 32'd0);
        chk("rst_rand", {30'd0, if1.rnd}, 32'd0);
        chk("rst_fallback", {31'd0, if1.fallback}, 32'd0);
        chk("rst_reject_cnt", {16'd0, if1.reject_cnt}, 32'd0);

        // Table of draws, issued back to back (req in the valid cycle).
        for (int i = 0; i < 10; i++) begin
            start_draw(vecs[i].limit, vecs[i].exp_lim, vecs[i].sl, vecs[i].sa, vecs[i].sbs);
            finish_draw();
        end

        // req while busy is ignored: exactly one valid for the draw.
        start_draw(3'd1, 3'd1, 1'b1, 23'h000003, 21'h100000);
        k = sb[sb.size()-1].lat;
        nval = 0;
        if1.limit = 3'd4;
        for (int i = 1; i < k; i++) begin
            if1.req = 1'b1;
            tick();
            if (if1.valid === 1'b1) nval++;
        end
        if1.req = 1'b0;
        tick();
        if (if1.valid === 1'b1) nval++;
        e = sb.pop_front();
        chk("intf_rand", {30'd0, if1.rnd}, {30'd0, e.rnd});
        chk("intf_fallback", {31'd0, if1.fallback}, {31'd0, e.fb});
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if1.valid === 1'b1) nval++;
        end
        chk("intf_one_valid", nval, 32'd1);
        chk("intf_idle", {31'd0, if1.busy}, 32'd0);

        // Reset mid-draw aborts: no valid, outputs back to reset values.
        start_draw(3'd1, 3'd1, 1'b1, 23'h000003, 21'h100000);
        void'(sb.pop_back());
        tick();
        chk("mid_busy_before_rst", {31'd0, if1.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, if1.busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, if1.valid}, 32'd0);
        chk("mid_rst_rand", {30'd0, if1.rnd}, 32'd0);
        chk("mid_rst_fallback", {31'd0, if1.fallback}, 32'd0);
        chk("mid_rst_reject_cnt", {16'd0, if1.reject_cnt}, 32'd0);
        nval = 0;
        for (int i = 0; i < MAX_TRIES + 4; i++) begin
            tick();
            if (if1.valid === 1'b1) nval++;
        end
        chk("mid_rst_no_valid", nval, 32'd0);

        // Forced fallback on the single-try instance: sample 3 vs limit 3.
        if2.req = 1'b1; if2.limit = 3'd3; if2.seed_load = 1'b1;
        if2.seed_a = 23'h000003; if2.seed_b = 21'h100000;
        tick();
        if2.req = 1'b0; if2.seed_load = 1'b0;
        chk("fb_busy", {31'd0, if2.busy}, 32'd1);
        tick();
        chk("fb_valid", {31'd0, if2.valid}, 32'd1);
        chk("fb_rand", {30'd0, if2.rnd}, 32'd0);
        chk("fb_flag", {31'd0, if2.fallback}, 32'd1);
`ifdef RAND_STATS_EN
        chk("fb_reject_cnt", {16'd0, if2.reject_cnt}, 32'd1);
`else
        chk("fb_reject_cnt", {16'd0, if2.reject_cnt}, 32'd0);
`endif
        tick();
        chk("fb_valid_pulse", {31'd0, if2.valid}, 32'd0);
        chk("fb_held", {31'd0, if2.fallback}, 32'd1);

        // Full range distribution: 1000 draws with limit 4.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 1000; i++) begin
            start_draw(3'd4, 3'd4, 1'b0, 23'h0, 21'h0);
            finish_draw();
            cnt[if1.rnd]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cnt[i] < 190 || cnt[i] > 310) begin
                n_err++;
                $display("FAIL dist_%0d: got count %0d required 190..310", i, cnt[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
